// File: rtl/lectura_rtc.sv
// Read sequencer for the multiplexed address/data RTC bus.
// Walks the register map into shadows, then commits every shadow to the outputs on one edge.
module lectura_rtc (
  input  logic       clk,
  input  logic       reset,
  input  logic       Lectura,
  input  logic       Lee_timer,
  input  logic       DIR,
  input  logic       DAT,
  input  logic       cambio_estado,
  input  logic [7:0] Dato_in,
  output logic [7:0] Dato_Dire,
  output logic       E_lec,
  output logic       Term_Lec,
  output logic [7:0] Seg,
  output logic [7:0] Min,
  output logic [7:0] Hora,
  output logic [7:0] Dia,
  output logic [7:0] Mes,
  output logic [7:0] Ano,
  output logic [7:0] T_Seg,
  output logic [7:0] T_Min,
  output logic [7:0] T_Hora
);

  typedef enum logic [3:0] {
    IDLE, CMD, R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO,
    R_TSEG, R_TMIN, R_THORA, DONE
  } state_t;

  state_t state, state_next;

  logic             lt_reg;
  logic [8:0][7:0]  shadow;
  logic [8:0][7:0]  committed;
  logic [7:0]       addr;
  logic [3:0]       sh_idx;
  logic             has_shadow;
  logic             on_bus;
  logic             advance;
  logic             commit;

  // Address and shadow slot owned by the current state.
  always_comb begin
    addr       = 8'h00;
    sh_idx     = 4'd0;
    has_shadow = 1'b1;
    case (state)
      CMD:     begin addr = 8'hF0; has_shadow = 1'b0; end
      R_SEG:   begin addr = 8'h21; sh_idx = 4'd0; end
      R_MIN:   begin addr = 8'h22; sh_idx = 4'd1; end
      R_HORA:  begin addr = 8'h23; sh_idx = 4'd2; end
      R_DIA:   begin addr = 8'h24; sh_idx = 4'd3; end
      R_MES:   begin addr = 8'h25; sh_idx = 4'd4; end
      R_ANO:   begin addr = 8'h26; sh_idx = 4'd5; end
      R_TSEG:  begin addr = 8'h41; sh_idx = 4'd6; end
      R_TMIN:  begin addr = 8'h42; sh_idx = 4'd7; end
      R_THORA: begin addr = 8'h43; sh_idx = 4'd8; end
      default: has_shadow = 1'b0;
    endcase
  end

  assign on_bus  = (state != IDLE) && (state != DONE);
  assign advance = on_bus && !DIR && !DAT && cambio_estado;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Lectura) state_next = CMD;
      CMD:     if (advance) state_next = R_SEG;
      R_SEG:   if (advance) state_next = R_MIN;
      R_MIN:   if (advance) state_next = R_HORA;
      R_HORA:  if (advance) state_next = R_DIA;
      R_DIA:   if (advance) state_next = R_MES;
      R_MES:   if (advance) state_next = R_ANO;
      R_ANO:   if (advance) state_next = lt_reg ? R_TSEG : DONE;
      R_TSEG:  if (advance) state_next = R_TMIN;
      R_TMIN:  if (advance) state_next = R_THORA;
      R_THORA: if (advance) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    E_lec    = (state != IDLE);
    Term_Lec = (state == DONE);
  end

  assign commit = (state_next == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      lt_reg    <= 1'b0;
      Dato_Dire <= 8'h00;
      shadow    <= '0;
      committed <= '0;
    end else begin
      if (state == IDLE && Lectura)
        lt_reg <= Lee_timer;
      if (on_bus) begin
        if (DIR)
          Dato_Dire <= addr;
        else if (DAT && has_shadow)
          shadow[sh_idx] <= Dato_in;
      end
      // Single-edge commit so readers never see a half-updated time.
      if (commit) begin
        for (int i = 0; i < 6; i++) committed[i] <= shadow[i];
        if (lt_reg)
          for (int i = 6; i < 9; i++) committed[i] <= shadow[i];
      end
    end
  end

  assign Seg    = committed[0];
  assign Min    = committed[1];
  assign Hora   = committed[2];
  assign Dia    = committed[3];
  assign Mes    = committed[4];
  assign Ano    = committed[5];
  assign T_Seg  = committed[6];
  assign T_Min  = committed[7];
  assign T_Hora = committed[8];

endmodule
